fnd_scan_driver: RTL and testbench

- Parametrised, time-multiplexed driver for a DIGITS-wide common-electrode 7-segment (FND) bank.
- Latches a packed hex value, decodes the full 0-F range per digit and drives one shared segment bus plus one common line per digit.
- Scanned at a programmable rate, with anti-ghost blanking, leading-zero suppression and per-digit decimal point and blank controls.
- Sits between the counter/datapath logic and the board display pins.

---
 rtl/fnd_scan_driver.sv | 171 +++++++++++++++++
 tb/tb_fnd_scan_driver.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed hex 7-segment driver: frame-synchronous value update,
// anti-ghost blanking, leading-zero suppression, per-digit DP and blank.
module fnd_scan_driver #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned REFRESH_DIV    = 1000,
    parameter int unsigned BLANK_CYC      = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          COM_ACTIVE_LOW = 1'b1,
    parameter bit          LZ_BLANK       = 1'b1
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [4*DIGITS-1:0]   i_Num,
    input  logic                  i_Load,
    input  logic [DIGITS-1:0]     i_DP,
    input  logic [DIGITS-1:0]     i_Blank,
    output logic [6:0]            o_FND,
    output logic                  o_DP,
    output logic [DIGITS-1:0]     o_Com,
    output logic                  o_Frame
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    // XOR masks that turn active-high "on" into pin levels; also the "off" levels
    localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] COM_OFF = {DIGITS{COM_ACTIVE_LOW}};

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic                slot_end;
    logic                frame_edge;
    logic                blank_done;

    logic [4*DIGITS-1:0] sh_num;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blank;
    logic [4*DIGITS-1:0] ds_num;
    logic [DIGITS-1:0]   ds_dp;
    logic [DIGITS-1:0]   ds_blank;

    logic [DIGITS-1:0]   suppress;
    logic                all_zero;
    logic [3:0]          nib;
    logic                cur_sup;
    logic                cur_dp;
    logic [DIGITS-1:0]   com_sel;
    logic [6:0]          seg_on;
    logic                dp_on;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0:    decode = 7'b1111110;
            4'h1:    decode = 7'b0110000;
            4'h2:    decode = 7'b1101101;
            4'h3:    decode = 7'b1111001;
            4'h4:    decode = 7'b0110011;
            4'h5:    decode = 7'b1011011;
            4'h6:    decode = 7'b1011111;
            4'h7:    decode = 7'b1110000;
            4'h8:    decode = 7'b1111111;
            4'h9:    decode = 7'b1111011;
            4'hA:    decode = 7'b1110111;
            4'hB:    decode = 7'b0011111;
            4'hC:    decode = 7'b1001110;
            4'hD:    decode = 7'b0111101;
            4'hE:    decode = 7'b1001111;
            default: decode = 7'b1000111;
        endcase
    endfunction

    assign slot_end   = (presc == PRESC_LAST);
    assign frame_edge = slot_end && (idx == IDX_LAST);

    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign blank_done = 1'b1;
        end else begin : g_blank
            assign blank_done = (presc >= PW'(BLANK_CYC));
        end
    endgenerate

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (slot_end) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Display registers change only on the frame edge; a load on that very
    // edge bypasses the shadow so no stale frame is shown.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sh_num   <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            ds_num   <= '0;
            ds_dp    <= '0;
            ds_blank <= '0;
        end else begin
            if (i_Load) begin
                sh_num   <= i_Num;
                sh_dp    <= i_DP;
                sh_blank <= i_Blank;
            end
            if (frame_edge) begin
                if (i_Load) begin
                    ds_num   <= i_Num;
                    ds_dp    <= i_DP;
                    ds_blank <= i_Blank;
                end else begin
                    ds_num   <= sh_num;
                    ds_dp    <= sh_dp;
                    ds_blank <= sh_blank;
                end
            end
        end
    end

    // Walk from the most significant digit down, tracking "all zero so far".
    always_comb begin
        suppress = '0;
        all_zero = 1'b1;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            all_zero = all_zero && (ds_num[(DIGITS-1-j)*4 +: 4] == 4'h0);
            suppress[DIGITS-1-j] = ds_blank[DIGITS-1-j] ||
                                   (LZ_BLANK && (DIGITS-1-j != 0) && all_zero);
        end
    end

    always_comb begin
        nib     = '0;
        cur_sup = 1'b0;
        cur_dp  = 1'b0;
        com_sel = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib        = ds_num[k*4 +: 4];
                cur_sup    = suppress[k];
                cur_dp     = ds_dp[k];
                com_sel[k] = blank_done;
            end
        end
        seg_on = cur_sup ? 7'b0000000 : decode(nib);
        dp_on  = cur_dp && !cur_sup;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_FND   <= SEG_OFF;
            o_DP    <= DP_OFF;
            o_Com   <= COM_OFF;
            o_Frame <= 1'b0;
        end else begin
            o_FND   <= seg_on ^ SEG_OFF;
            o_DP    <= dp_on ^ DP_OFF;
            o_Com   <= com_sel ^ COM_OFF;
            o_Frame <= frame_edge;
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Bench for fnd_scan_driver (4 digits, 4 clocks/slot, 1 blank clock, active-low),
// with a second instance that has leading-zero suppression disabled.
module tb_fnd_scan_driver;

    localparam int unsigned D  = 4;
    localparam int unsigned R  = 4;
    localparam int unsigned BC = 1;
    localparam int unsigned FR = D * R;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    logic        clk;
    logic        rst;
    logic [15:0] num;
    logic        load;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [6:0]  fnd,   fnd_n;
    logic        dpo,   dpo_n;
    logic [3:0]  com,   com_n;
    logic        frame, frame_n;

    int n_checks;
    int n_pass;

    // reference model state
    int unsigned m_cyc;
    logic [15:0] sh_num, ds_num;
    logic [3:0]  sh_dp, sh_blk, ds_dp, ds_blk;
    logic [3:0]  e_com;
    logic [6:0]  e_fnd, e_fnd_n;
    logic        e_dp, e_dp_n, e_frame;

    fnd_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1),
                      .SEG_ACTIVE_LOW(1'b1), .COM_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)) u_dut (
        .i_Clk(clk), .i_Rst(rst), .i_Num(num), .i_Load(load), .i_DP(dp), .i_Blank(blank),
        .o_FND(fnd), .o_DP(dpo), .o_Com(com), .o_Frame(frame));

    fnd_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1),
                      .SEG_ACTIVE_LOW(1'b1), .COM_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)) u_nolz (
        .i_Clk(clk), .i_Rst(rst), .i_Num(num), .i_Load(load), .i_DP(dp), .i_Blank(blank),
        .o_FND(fnd_n), .o_DP(dpo_n), .o_Com(com_n), .o_Frame(frame_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin levels (active-low) for digit k of a displayed value.
    function automatic void model_digit(input logic [15:0] v, input logic [3:0] dpv,
                                        input logic [3:0] blk, input int unsigned k,
                                        input bit lz, output logic [6:0] seg,
                                        output logic dpl);
        logic [15:0] upper;
        bit          sup;
        upper = v >> (4 * k);
        sup   = blk[k] || (lz && k > 0 && upper == 16'h0);
        if (sup) begin
            seg = 7'h7F;
            dpl = 1'b1;
        end else begin
            seg = ~SEG_TAB[upper[3:0]];
            dpl = ~dpv[k];
        end
    endfunction

    task automatic model_clear();
        m_cyc  = 0;
        sh_num = '0; sh_dp = '0; sh_blk = '0;
        ds_num = '0; ds_dp = '0; ds_blk = '0;
    endtask

    // Drive one cycle's inputs, predict outputs after the next rising edge,
    // advance the model, and return at the following falling edge.
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] dpv,
                        input logic [3:0] blk);
        int unsigned slot, pos;
        load = ld; num = v; dp = dpv; blank = blk;
        slot = (m_cyc / R) % D;
        pos  = m_cyc % R;
        e_com = 4'hF;
        if (pos >= BC) e_com[slot] = 1'b0;
        model_digit(ds_num, ds_dp, ds_blk, slot, 1'b1, e_fnd, e_dp);
        model_digit(ds_num, ds_dp, ds_blk, slot, 1'b0, e_fnd_n, e_dp_n);
        e_frame = ((m_cyc + 1) % FR) == 0;
        if (e_frame) begin
            if (ld) begin ds_num = v; ds_dp = dpv; ds_blk = blk; end
            else begin ds_num = sh_num; ds_dp = sh_dp; ds_blk = sh_blk; end
        end
        if (ld) begin sh_num = v; sh_dp = dpv; sh_blk = blk; end
        m_cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (com !== 4'hF) $display("FAIL rst_com got %b want 1111", com); else n_pass++;
        n_checks++; if (fnd !== 7'h7F) $display("FAIL rst_fnd got %b want 1111111", fnd); else n_pass++;
        n_checks++; if (dpo !== 1'b1) $display("FAIL rst_dp got %b want 1", dpo); else n_pass++;
        n_checks++; if (frame !== 1'b0) $display("FAIL rst_frame got %b want 0", frame); else n_pass++;
        n_checks++; if (com_n !== 4'hF || fnd_n !== 7'h7F)
            $display("FAIL rst_nolz got com=%b fnd=%b want 1111/1111111", com_n, fnd_n); else n_pass++;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_idle_scan();
        int frames;
        frames = 0;
        repeat (32) begin
            step(1'b0, 16'h0, 4'h0, 4'h0);
            n_checks++; if (com !== e_com) $display("FAIL idle_com t=%0t got %b want %b", $time, com, e_com); else n_pass++;
            n_checks++; if (fnd !== e_fnd) $display("FAIL idle_fnd t=%0t got %b want %b", $time, fnd, e_fnd); else n_pass++;
            n_checks++; if (frame !== e_frame) $display("FAIL idle_frame t=%0t got %b want %b", $time, frame, e_frame); else n_pass++;
            if (frame === 1'b1) frames++;
            if (com === 4'b1110) begin
                n_checks++; if (fnd !== 7'b0000001) $display("FAIL idle_digit0 got %b want 0000001", fnd); else n_pass++;
            end else if (com !== 4'b1111) begin
                n_checks++; if (fnd !== 7'h7F) $display("FAIL idle_lz got %b want 1111111", fnd); else n_pass++;
            end
        end
        n_checks++; if (frames != 2) $display("FAIL idle_frame_count got %0d want 2", frames); else n_pass++;
    endtask

    task automatic test_load_value();
        bit seen;
        seen = 1'b0;
        repeat (5) step(1'b0, 16'h0, 4'h0, 4'h0);
        step(1'b1, 16'h0A5F, 4'b0100, 4'b0000);
        repeat (40) begin
            step(1'b0, 16'h0, 4'h0, 4'h0);
            n_checks++; if (fnd !== e_fnd || dpo !== e_dp || com !== e_com)
                $display("FAIL load_model t=%0t got %b/%b/%b want %b/%b/%b", $time, com, fnd, dpo, e_com, e_fnd, e_dp); else n_pass++;
            n_checks++; if (fnd_n !== e_fnd_n || dpo_n !== e_dp_n)
                $display("FAIL load_nolz t=%0t got %b/%b want %b/%b", $time, fnd_n, dpo_n, e_fnd_n, e_dp_n); else n_pass++;
            if (seen && com === 4'b1110) begin
                n_checks++; if (fnd !== 7'b0111000) $display("FAIL load_d0 got %b want 0111000", fnd); else n_pass++;
            end
            if (seen && com === 4'b1101) begin
                n_checks++; if (fnd !== 7'b0100100) $display("FAIL load_d1 got %b want 0100100", fnd); else n_pass++;
            end
            if (seen && com === 4'b1011) begin
                n_checks++; if (fnd !== 7'b0001000 || dpo !== 1'b0)
                    $display("FAIL load_d2 got %b/%b want 0001000/0", fnd, dpo); else n_pass++;
            end
            if (seen && com === 4'b0111) begin
                n_checks++; if (fnd !== 7'h7F) $display("FAIL load_d3 got %b want 1111111", fnd); else n_pass++;
            end
            if (frame === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_tearing();
        while ((m_cyc % FR) != 6) step(1'b0, 16'h0, 4'h0, 4'h0);
        step(1'b1, 16'h1000, 4'h0, 4'h0);
        while ((m_cyc % FR) != 0) begin
            step(1'b0, 16'h0, 4'h0, 4'h0);
            n_checks++; if (fnd !== e_fnd || com !== e_com)
                $display("FAIL tear_model t=%0t got %b/%b want %b/%b", $time, com, fnd, e_com, e_fnd); else n_pass++;
            if (com === 4'b1101) begin
                n_checks++; if (fnd !== 7'b0100100) $display("FAIL tear_hold got %b want 0100100", fnd); else n_pass++;
            end
        end
        repeat (16) begin
            step(1'b0, 16'h0, 4'h0, 4'h0);
            n_checks++; if (fnd !== e_fnd || dpo !== e_dp)
                $display("FAIL tear_new t=%0t got %b/%b want %b/%b", $time, fnd, dpo, e_fnd, e_dp); else n_pass++;
            if (com === 4'b0111) begin
                n_checks++; if (fnd !== 7'b1001111) $display("FAIL tear_d3 got %b want 1001111", fnd); else n_pass++;
            end else if (com !== 4'b1111) begin
                n_checks++; if (fnd !== 7'b0000001) $display("FAIL tear_inner0 got %b want 0000001", fnd); else n_pass++;
            end
        end
        step(1'b1, 16'h0007, 4'h0, 4'h0);
        while ((m_cyc % FR) != 0) step(1'b0, 16'h0, 4'h0, 4'h0);
        repeat (16) begin
            step(1'b0, 16'h0, 4'h0, 4'h0);
            n_checks++; if (fnd_n !== e_fnd_n || com_n !== e_com)
                $display("FAIL nolz_model t=%0t got %b/%b want %b/%b", $time, com_n, fnd_n, e_com, e_fnd_n); else n_pass++;
            if (com_n === 4'b1110) begin
                n_checks++; if (fnd_n !== 7'b0001111) $display("FAIL nolz_d0 got %b want 0001111", fnd_n); else n_pass++;
            end else if (com_n !== 4'b1111) begin
                n_checks++; if (fnd_n !== 7'b0000001) $display("FAIL nolz_upper got %b want 0000001", fnd_n); else n_pass++;
                n_checks++; if (fnd !== 7'h7F) $display("FAIL lz_upper got %b want 1111111", fnd); else n_pass++;
            end
        end
    endtask

    task automatic test_bypass();
        while (((m_cyc + 1) % FR) != 0) step(1'b0, 16'h0, 4'h0, 4'h0);
        step(1'b1, 16'hBEEF, 4'b1010, 4'b0000);
        n_checks++; if (frame !== 1'b1) $display("FAIL bypass_frame got %b want 1", frame); else n_pass++;
        step(1'b0, 16'h0, 4'h0, 4'h0);
        n_checks++; if (fnd !== 7'b0111000 || dpo !== 1'b1)
            $display("FAIL bypass_slot0 got %b/%b want 0111000/1", fnd, dpo); else n_pass++;
        n_checks++; if (frame !== 1'b0) $display("FAIL bypass_frame_once got %b want 0", frame); else n_pass++;
        repeat (15) begin
            step(1'b0, 16'h0, 4'h0, 4'h0);
            n_checks++; if (fnd !== e_fnd || dpo !== e_dp || com !== e_com)
                $display("FAIL bypass_model t=%0t got %b/%b/%b want %b/%b/%b", $time, com, fnd, dpo, e_com, e_fnd, e_dp); else n_pass++;
        end
    endtask

    task automatic test_blank_dp();
        bit seen;
        seen = 1'b0;
        step(1'b1, 16'h1234, 4'b0001, 4'b0001);
        repeat (36) begin
            step(1'b0, 16'h0, 4'h0, 4'h0);
            n_checks++; if (fnd !== e_fnd || dpo !== e_dp)
                $display("FAIL blank_model t=%0t got %b/%b want %b/%b", $time, fnd, dpo, e_fnd, e_dp); else n_pass++;
            if (seen && com === 4'b1110) begin
                n_checks++; if (fnd !== 7'h7F || dpo !== 1'b1)
                    $display("FAIL blank_d0 got %b/%b want 1111111/1", fnd, dpo); else n_pass++;
            end
            if (frame === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        bit first;
        first = 1'b1;
        while ((m_cyc % FR) != 10) step(1'b0, 16'h0, 4'h0, 4'h0);
        n_checks++; if (com !== 4'b1011) $display("FAIL arst_pre got %b want 1011", com); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (com !== 4'hF || com_n !== 4'hF) $display("FAIL arst_com got %b want 1111", com); else n_pass++;
        n_checks++; if (fnd !== 7'h7F || dpo !== 1'b1)
            $display("FAIL arst_seg got %b/%b want 1111111/1", fnd, dpo); else n_pass++;
        n_checks++; if (frame !== 1'b0) $display("FAIL arst_frame got %b want 0", frame); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (16) begin
            step(1'b0, 16'h0, 4'h0, 4'h0);
            n_checks++; if (fnd !== e_fnd || com !== e_com || frame !== e_frame)
                $display("FAIL arst_model t=%0t got %b/%b/%b want %b/%b/%b", $time, com, fnd, frame, e_com, e_fnd, e_frame); else n_pass++;
            if (first && com !== 4'hF) begin
                first = 1'b0;
                n_checks++; if (com !== 4'b1110 || fnd !== 7'b0000001)
                    $display("FAIL arst_resume got %b/%b want 1110/0000001", com, fnd); else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic        ld;
        logic [15:0] v;
        logic [3:0]  dv, bv;
        repeat (400) begin
            ld = ($urandom_range(0, 5) == 0);
            v  = 16'($urandom);
            if ($urandom_range(0, 1) == 0) v = v & 16'h00FF;
            dv = 4'($urandom);
            bv = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            step(ld, v, dv, bv);
            n_checks++; if (com !== e_com || com_n !== e_com)
                $display("FAIL rand_com t=%0t got %b/%b want %b", $time, com, com_n, e_com); else n_pass++;
            n_checks++; if (fnd !== e_fnd || dpo !== e_dp)
                $display("FAIL rand_seg t=%0t got %b/%b want %b/%b", $time, fnd, dpo, e_fnd, e_dp); else n_pass++;
            n_checks++; if (fnd_n !== e_fnd_n || dpo_n !== e_dp_n)
                $display("FAIL rand_nolz t=%0t got %b/%b want %b/%b", $time, fnd_n, dpo_n, e_fnd_n, e_dp_n); else n_pass++;
            n_checks++; if (frame !== e_frame || frame_n !== e_frame)
                $display("FAIL rand_frame t=%0t got %b/%b want %b", $time, frame, frame_n, e_frame); else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst   = 1'b1;
        load  = 1'b0;
        num   = '0;
        dp    = '0;
        blank = '0;
        model_clear();
        test_reset();
        test_idle_scan();
        test_load_value();
        test_tearing();
        test_bypass();
        test_blank_dp();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
